// File: rtl/ws2812_pkg.sv
// Shared types, widths and default timing for the WS2812 frame driver.
package ws2812_pkg;

    localparam int unsigned COLOR_W = 24;
    localparam int unsigned IDX_W   = 7;

    // 50 MHz defaults
    localparam int unsigned DEF_NUM_PIXELS = 128;
    localparam int unsigned DEF_T0H_CYC    = 20;
    localparam int unsigned DEF_T1H_CYC    = 40;
    localparam int unsigned DEF_TBIT_CYC   = 63;
    localparam int unsigned DEF_LATCH_CYC  = 3000;

    typedef enum logic [1:0] {StIdle, StLoad, StBit, StLatch} ws_state_e;

    // Each 8-bit channel is dimmed independently so G, R and B keep their ratio.
    function automatic logic [COLOR_W-1:0] scale_grb(input logic [COLOR_W-1:0] color,
                                                     input logic [1:0]         shift);
        logic [COLOR_W-1:0] res;
        res = '0;
        for (int i = 0; i < 3; i++) begin
            res[i*8 +: 8] = color[i*8 +: 8] >> shift;
        end
        return res;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Generates one WS2812 bit waveform per start strobe; bit_done marks its last cycle.
module ws2812_bit_encoder #(
    parameter int unsigned T0H_CYC  = 20,
    parameter int unsigned T1H_CYC  = 40,
    parameter int unsigned TBIT_CYC = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_val,
    output logic dout,
    output logic bit_done
);

    localparam int unsigned CNT_W = $clog2(TBIT_CYC);
    localparam logic [CNT_W-1:0] T0H   = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] T1H   = CNT_W'(T1H_CYC);
    localparam logic [CNT_W-1:0] TLAST = CNT_W'(TBIT_CYC - 1);

    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic             active_q, active_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_q <= '0;
            active_q  <= 1'b0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            active_q  <= active_d;
        end
    end

    assign bit_done = active_q && (cyc_cnt_q == TLAST);
    assign dout     = active_q && (cyc_cnt_q < (bit_val ? T1H : T0H));

    // A start on the final cycle chains straight into the next bit with no gap.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        active_d  = active_q;
        if (start) begin
            cyc_cnt_d = '0;
            active_d  = 1'b1;
        end else if (bit_done) begin
            cyc_cnt_d = '0;
            active_d  = 1'b0;
        end else if (active_q) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_frame_driver.sv
// WS2812 strip frame driver: walks pixels, captures GRB colour, serialises, then latches.
// Optional macro WS_BRIGHTNESS_EN adds a brightness[1:0] per-channel right-shift at capture.
module ws2812_frame_driver
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int unsigned T0H_CYC    = DEF_T0H_CYC,
    parameter int unsigned T1H_CYC    = DEF_T1H_CYC,
    parameter int unsigned TBIT_CYC   = DEF_TBIT_CYC,
    parameter int unsigned LATCH_CYC  = DEF_LATCH_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic [IDX_W-1:0]   pixel_idx,
    input  logic [COLOR_W-1:0] color_in,
`ifdef WS_BRIGHTNESS_EN
    input  logic [1:0]         brightness,
`endif
    output logic               dout,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned LAT_W = $clog2(LATCH_CYC);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYC - 1);
    localparam logic [4:0]       LAST_BIT = 5'(COLOR_W - 1);
    localparam logic [IDX_W-1:0] LAST_PIX = IDX_W'(NUM_PIXELS - 1);

    ws_state_e          state_q, state_d;
    logic [IDX_W-1:0]   pixel_idx_q;
    logic [COLOR_W-1:0] shreg_q;
    logic [COLOR_W-1:0] capture;
    logic [4:0]         bit_cnt_q;
    logic [LAT_W-1:0]   latch_cnt_q;
    logic               enc_start, enc_done;
    logic               last_bit, last_pixel;

`ifdef WS_BRIGHTNESS_EN
    assign capture = scale_grb(color_in, brightness);
`else
    assign capture = color_in;
`endif

    assign last_bit   = (bit_cnt_q == LAST_BIT);
    assign last_pixel = (pixel_idx_q == LAST_PIX);
    assign pixel_idx  = pixel_idx_q;

    ws2812_bit_encoder #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_bit_encoder (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (enc_start),
        .bit_val  (shreg_q[COLOR_W-1]),
        .dout     (dout),
        .bit_done (enc_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StLoad;
            StLoad:  state_d = StBit;
            StBit:   if (enc_done && last_bit) state_d = last_pixel ? StLatch : StLoad;
            StLatch: if (latch_cnt_q == LAT_LAST) state_d = enable ? StLoad : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        enc_start  = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StLoad: begin
                busy      = 1'b1;
                enc_start = 1'b1;
            end
            StBit: begin
                busy      = 1'b1;
                enc_start = enc_done && !last_bit;
            end
            StLatch: begin
                busy       = 1'b1;
                frame_done = (latch_cnt_q == LAT_LAST);
            end
            default: ;
        endcase
    end

    // The shift happens on the same edge the encoder rearms, so the next bit sees the new MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_idx_q <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            latch_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle:  pixel_idx_q <= '0;
                StLoad: begin
                    shreg_q   <= capture;
                    bit_cnt_q <= '0;
                end
                StBit: begin
                    if (enc_done) begin
                        shreg_q   <= {shreg_q[COLOR_W-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (last_bit) begin
                            latch_cnt_q <= '0;
                            pixel_idx_q <= last_pixel ? '0 : pixel_idx_q + 1'b1;
                        end
                    end
                end
                StLatch: latch_cnt_q <= latch_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Bench for ws2812_frame_driver: cycle-exact frame waveform against a spec-level model.
module tb_ws2812_frame_driver;

    localparam int NP        = 2;
    localparam int T0H       = 3;
    localparam int T1H       = 6;
    localparam int TBIT      = 10;
    localparam int LATCH     = 20;
    localparam int PIX_CYC   = 1 + 24 * TBIT;
    localparam int FRAME_CYC = NP * PIX_CYC + LATCH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [6:0]  pixel_idx;
    logic [23:0] color_in;
    logic        dout, busy, frame_done;
`ifdef WS_BRIGHTNESS_EN
    logic [1:0]  brightness = 2'd0;
`endif

    logic [23:0] lut [NP];
    logic [23:0] noise = 24'h0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [23:0] c0, c1;
        logic [1:0]  br;
        logic [23:0] e0, e1;
        int          drop_at;
        bit          use_noise;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    // Comparator stand-in: a lookup by pixel index, optionally corrupted outside LOAD.
    assign color_in = ((pixel_idx < 7'(NP)) ? lut[pixel_idx[0]] : 24'h0) ^ noise;

    ws2812_frame_driver #(
        .NUM_PIXELS (NP),
        .T0H_CYC    (T0H),
        .T1H_CYC    (T1H),
        .TBIT_CYC   (TBIT),
        .LATCH_CYC  (LATCH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pixel_idx  (pixel_idx),
        .color_in   (color_in),
`ifdef WS_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] ref_scale(input logic [23:0] c, input int sh);
        logic [23:0] r;
        int chan;
        r = 24'h0;
        for (int i = 0; i < 3; i++) begin
            chan = int'((c >> (8 * i)) & 24'hff);
            r = r | (24'(chan >> sh) << (8 * i));
        end
        return r;
    endfunction

    function automatic bit is_load(input int k);
        return (k >= 1) && (k <= NP * PIX_CYC) && (((k - 1) % PIX_CYC) == 0);
    endfunction

    // Expected {dout, busy, frame_done, pixel_idx} for cycle k of a frame (k=1 is the first LOAD).
    function automatic logic [9:0] model_cycle(input int k, input logic [23:0] w0,
                                               input logic [23:0] w1);
        int p, off, b, c;
        logic [23:0] w;
        logic d;
        if (k <= NP * PIX_CYC) begin
            p   = (k - 1) / PIX_CYC;
            off = (k - 1) % PIX_CYC;
            w   = (p == 0) ? w0 : w1;
            if (off == 0) begin
                d = 1'b0;
            end else begin
                b = (off - 1) / TBIT;
                c = (off - 1) % TBIT;
                d = (c < (w[23 - b] ? T1H : T0H));
            end
            return {d, 1'b1, 1'b0, 7'(p)};
        end
        return {1'b0, 1'b1, (k == FRAME_CYC), 7'd0};
    endfunction

    function automatic logic [31:0] obs();
        return 32'({dout, busy, frame_done, pixel_idx});
    endfunction

    // Call right after a negedge with the DUT idle; the next posedge enters LOAD.
    task automatic run_frame(input logic [23:0] w0, input logic [23:0] w1, input int drop_at,
                             input bit use_noise);
        bit seen;
        enable = 1'b1;
        noise  = 24'h0;
        for (int k = 1; k <= FRAME_CYC; k++) begin
            @(negedge clk);
            chk("frame", k, obs(), 32'(model_cycle(k, w0, w1)));
            if (k == drop_at) enable = 1'b0;
            noise = (use_noise && !is_load(k)) ? 24'($urandom) : 24'h0;
        end
        noise = 24'h0;
        if (drop_at <= FRAME_CYC) begin
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                chk("idle_after_frame", FRAME_CYC + i, obs(), 32'h0);
            end
        end else begin
            @(negedge clk);
            chk("restart_load", FRAME_CYC + 1, obs(), 32'(model_cycle(1, w0, w1)));
            enable = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < FRAME_CYC + 10 && !seen; i++) begin
                @(negedge clk);
                if (frame_done) seen = 1'b1;
            end
            chk("second_frame_done", 0, 32'(seen), 32'h1);
            @(negedge clk);
            chk("idle_after_second", 0, obs(), 32'h0);
        end
    endtask

    initial begin
        vec_t v;
        logic [23:0] a, b;
        int br;

        vecs.push_back('{24'h00ff00, 24'h000000, 2'd0, 24'h00ff00, 24'h000000, 1,    1'b0});
        vecs.push_back('{24'h800001, 24'hffffff, 2'd0, 24'h800001, 24'hffffff, 300,  1'b0});
        vecs.push_back('{24'ha5c35a, 24'h0f0f0f, 2'd0, 24'ha5c35a, 24'h0f0f0f, 5,    1'b1});
        vecs.push_back('{24'h123456, 24'hfedcba, 2'd0, 24'h123456, 24'hfedcba, 1000, 1'b1});
`ifdef WS_BRIGHTNESS_EN
        vecs.push_back('{24'hb70cf2, 24'hb70cf2, 2'd2, 24'h2d033c, 24'h2d033c, 1,    1'b0});
`endif
        for (int i = 0; i < 5; i++) begin
            a  = 24'($urandom);
            b  = 24'($urandom);
`ifdef WS_BRIGHTNESS_EN
            br = int'($urandom_range(0, 3));
`else
            br = 0;
`endif
            vecs.push_back('{a, b, 2'(br), ref_scale(a, br), ref_scale(b, br),
                             int'($urandom_range(1, 600)), 1'($urandom)});
        end

        lut[0] = 24'h0;
        lut[1] = 24'h0;
        #12;
        chk("reset_state", 0, obs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_disabled", 0, obs(), 32'h0);

        foreach (vecs[i]) begin
            v = vecs[i];
            lut[0] = v.c0;
            lut[1] = v.c1;
`ifdef WS_BRIGHTNESS_EN
            brightness = v.br;
`endif
            run_frame(v.e0, v.e1, v.drop_at, v.use_noise);
        end

`ifdef WS_BRIGHTNESS_EN
        brightness = 2'd0;
`endif
        // Asynchronous reset in the first (high) cycle of pixel 1 bit 0, then restart.
        lut[0] = 24'h3c00c3;
        lut[1] = 24'h000000;
        enable = 1'b1;
        for (int k = 1; k <= PIX_CYC + 2; k++) begin
            @(negedge clk);
            chk("pre_reset", k, obs(), 32'(model_cycle(k, lut[0], lut[1])));
        end
        #1 rst_n = 1'b0;
        #1 chk("async_reset", 0, obs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(24'h3c00c3, 24'h000000, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_driver.md
Name: ws2812_frame_driver

Overview:
- Serialises the needs-bar LED strip. Walks a pixel index 0..NUM_PIXELS-1 and drives it onto the need comparator's pixel-counter input.
- Captures the 24-bit colour the comparator returns combinationally, then shifts it out MSB-first on a single-wire WS2812 data line. Colour word is GRB byte order, already arranged upstream.
- Ends every frame with a latch (reset) low period. Free-runs frames while enabled.

Parameters:
- NUM_PIXELS, 128, pixels per frame; pixel_idx wraps after NUM_PIXELS-1.
- T0H_CYC, 20, high time of a '0' bit in clk cycles (0.4 us at 50 MHz).
- T1H_CYC, 40, high time of a '1' bit (0.8 us).
- TBIT_CYC, 63, total bit period (1.26 us); T1H_CYC < TBIT_CYC required.
- LATCH_CYC, 3000, low latch time after the last pixel (60 us).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run frames continuously while high
- pixel_idx  out  7  pixel index to comparator contadorpixel, registered
- color_in  in  24  colour from comparator colorout, GRB
- dout  out  1  WS2812 serial data line
- busy  out  1  high from frame start through end of latch
- frame_done  out  1  one-cycle pulse on last cycle of LATCH

Behaviour:
- Reset (async, rst_n=0): state IDLE, dout=0, pixel_idx=0, busy=0, frame_done=0, shift reg=0, counters=0. Reset mid-bit drops dout the same instant.
- FSM states: IDLE, LOAD, BIT, LATCH.
- IDLE: dout=0. If enable=1, go to LOAD with pixel_idx=0 and busy=1.
- LOAD (1 cycle): pixel_idx is already stable, so the comparator output settles this cycle.
  - At the end of the cycle, capture color_in into the 24-bit shift register.
  - Clear bit_cnt=0 and cyc_cnt=0, then go to BIT.
- BIT: the current bit is shreg[23].
  - dout=1 while cyc_cnt < (bit ? T1H_CYC : T0H_CYC), else 0.
  - cyc_cnt counts 0..TBIT_CYC-1. At TBIT_CYC-1: shift left 1 and increment bit_cnt.
  - After bit_cnt reaches 23 and completes:
    - If pixel_idx == NUM_PIXELS-1: go to LATCH, pixel_idx=0.
    - Otherwise pixel_idx+1, go to LOAD.
  - The 1-cycle LOAD gap extends the last low time by 20 ns, which is within WS2812 tolerance.
- LATCH: dout=0 for LATCH_CYC cycles. On the last cycle, frame_done=1.
  - Next state: LOAD (new frame) if enable=1, else IDLE with busy=0.
- enable deasserted mid-frame: the current frame completes including LATCH. No truncated pixels are ever sent.
- color_in changes outside LOAD are ignored; only the LOAD-cycle value is transmitted.
- Frame length = NUM_PIXELS*(1+24*TBIT_CYC) + LATCH_CYC cycles. With defaults this is 196664.
- pixel_idx values between bars (gaps in comparator map) are still sent; the comparator returns 0 there (dark LED).

Optional Feature:
- Macro WS_BRIGHTNESS_EN.
- Defined: adds input port brightness[1:0]. At LOAD, each 8-bit channel of color_in is logically right-shifted by brightness before capture (0 = full, 3 = 1/8).
- Undefined: no port; color_in is captured unchanged.

Decomposition:
- Package ws2812_pkg: state enum (IDLE, LOAD, BIT, LATCH), default timing constants, COLOR_W=24, IDX_W=7.
- One natural sub-module: ws2812_bit_encoder. It takes a bit value and a start strobe, generates the T0H/T1H/TBIT waveform, and returns a bit_done pulse. The frame FSM stays in the top.

Test Plan (bench params NUM_PIXELS=2, T0H_CYC=3, T1H_CYC=6, TBIT_CYC=10, LATCH_CYC=20; comparator modelled as a lookup):
- Reset then enable=1, color[0]=24'h00ff00, color[1]=24'h000000 -> pixel0 bits 0-7 show high 3 cycles, bits 8-15 high 6 cycles, bits 16-23 high 3 cycles; pixel1 all bits high 3; frame_done at cycle 502 after start.
- Bit-timing check on color 24'h800001 -> first bit high exactly 6 of 10 cycles, bits 1-22 high 3, last bit high 6.
- Drop enable in the middle of pixel1 -> frame finishes, LATCH 20 cycles low, frame_done pulses once, busy=0, IDLE, no new LOAD.
- Toggle color_in every cycle during BIT -> transmitted word equals the value sampled in the LOAD cycle only.
- Assert rst_n=0 while dout=1 mid-bit -> dout=0 asynchronously; pixel_idx=0; after release with enable=1, frame restarts at pixel 0.
- WS_BRIGHTNESS_EN defined, brightness=2, color 24'hb70cf2 -> serialised word 24'h2d033c.
